// File: rtl/serial_link_credit_ctrl.sv
// Credit-based flow-control stage between the network layer and the serial link data link layer.
// Optional forced credit return on idle: define SERIAL_LINK_CREDIT_TIMEOUT_EN.
module serial_link_credit_ctrl #(
  parameter  int DataWidth       = 64,
  parameter  int NumCredits      = 8,
  parameter  int ForceSendThresh = 6,
  parameter  int TimeoutCycles   = 32,
  localparam int CntW            = $clog2(NumCredits + 1),
  localparam int LinkW           = DataWidth + CntW + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DataWidth-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic [LinkW-1:0]     link_out_o,
  output logic                 link_out_valid_o,
  input  logic                 link_out_ready_i,
  input  logic [LinkW-1:0]     link_in_i,
  input  logic                 link_in_valid_i,
  output logic                 link_in_ready_o,
  output logic [DataWidth-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic [CntW-1:0]      credits_avail_o,
  output logic                 credit_overflow_o,
  output logic                 rx_overflow_o
);

  localparam int PtrW = $clog2(NumCredits);

  if (NumCredits < 2 || ForceSendThresh < 1 || ForceSendThresh > NumCredits ||
      TimeoutCycles < 1) begin : g_bad_cfg
    $error("serial_link_credit_ctrl: illegal parameter set");
  end

  typedef struct packed {
    logic                 is_data;
    logic [CntW-1:0]      credits;
    logic [DataWidth-1:0] data;
  } beat_t;

  beat_t                out_q;
  beat_t                in_beat;
  logic                 out_vld_q;
  logic [CntW-1:0]      credits_q;
  logic [CntW-1:0]      pending_q;
  logic                 credit_ovf_q;
  logic                 rx_ovf_q;

  logic                 loadable;
  logic                 load_data;
  logic                 load_cred;
  logic                 load;
  logic                 timeout;

  logic [DataWidth-1:0] mem [NumCredits];
  logic [PtrW-1:0]      rd_ptr;
  logic [PtrW-1:0]      wr_ptr;
  logic [CntW-1:0]      count_q;
  logic                 full;
  logic                 pop;
  logic                 push;
  logic                 drop;

  logic [CntW:0]        cred_sum;
  logic                 cred_ovf;

  assign in_beat = beat_t'(link_in_i);

  // TX load selection: payload first, then credit-only return, else drain.
  assign loadable  = ~out_vld_q | link_out_ready_i;
  assign load_data = ~rst_i & loadable & tx_valid_i & (credits_q != '0);
  assign load_cred = ~rst_i & loadable & ~load_data &
                     ((pending_q >= CntW'(ForceSendThresh)) | timeout);
  assign load      = load_data | load_cred;

  assign tx_ready_o       = load_data;
  assign link_in_ready_o  = ~rst_i;
  assign link_out_o       = out_q;
  assign link_out_valid_o = out_vld_q;
  assign credits_avail_o  = credits_q;
  assign credit_overflow_o = credit_ovf_q;
  assign rx_overflow_o    = rx_ovf_q;

  assign rx_valid_o = (count_q != '0);
  assign rx_data_o  = rx_valid_o ? mem[rd_ptr] : '0;
  assign full       = (count_q == CntW'(NumCredits));
  assign pop        = rx_valid_o & rx_ready_i;
  assign push       = link_in_valid_i & in_beat.is_data & (~full | pop);
  assign drop       = link_in_valid_i & in_beat.is_data & full & ~pop;

  // Returned credits and our own spend land in the same cycle; one extra bit catches overshoot.
  assign cred_sum = {1'b0, credits_q} - (CntW+1)'(load_data) +
                    (link_in_valid_i ? {1'b0, in_beat.credits} : '0);
  assign cred_ovf = cred_sum > (CntW+1)'(NumCredits);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_vld_q <= 1'b0;
      out_q     <= '0;
    end else if (loadable) begin
      out_vld_q <= load;
      if (load_data)      out_q <= '{is_data: 1'b1, credits: pending_q, data: tx_data_i};
      else if (load_cred) out_q <= '{is_data: 1'b0, credits: pending_q, data: '0};
      else                out_q <= '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      credits_q    <= CntW'(NumCredits);
      pending_q    <= '0;
      credit_ovf_q <= 1'b0;
      rx_ovf_q     <= 1'b0;
    end else begin
      credits_q    <= cred_ovf ? CntW'(NumCredits) : cred_sum[CntW-1:0];
      pending_q    <= load ? CntW'(pop) : pending_q + CntW'(pop);
      credit_ovf_q <= credit_ovf_q | cred_ovf;
      rx_ovf_q     <= rx_ovf_q | drop;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PtrW'(NumCredits - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PtrW'(NumCredits - 1)) ? '0 : rd_ptr + 1'b1;
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= in_beat.data;
  end

`ifdef SERIAL_LINK_CREDIT_TIMEOUT_EN
  localparam int IdleW = $clog2(TimeoutCycles + 1);
  logic [IdleW-1:0] idle_q;

  assign timeout = (pending_q != '0) && (idle_q == IdleW'(TimeoutCycles - 1));

  // Holds at the terminal count while the output register is back-pressured.
  always_ff @(posedge clk_i) begin
    if (rst_i || load || pending_q == '0) idle_q <= '0;
    else if (!timeout)                    idle_q <= idle_q + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_serial_link_credit_ctrl.sv
// Directed bench for serial_link_credit_ctrl: queue/integer reference model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_serial_link_credit_ctrl;
  localparam int DW = 64, N = 8, TH = 6, TO = 32;
  localparam int CW = $clog2(N + 1);
  localparam int LW = DW + CW + 1;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [DW-1:0] tx_data_i;
  logic          tx_valid_i, tx_ready_o;
  logic [LW-1:0] link_out_o;
  logic          link_out_valid_o, link_out_ready_i;
  logic [LW-1:0] link_in_i;
  logic          link_in_valid_i, link_in_ready_o;
  logic [DW-1:0] rx_data_o;
  logic          rx_valid_o, rx_ready_i;
  logic [CW-1:0] credits_avail_o;
  logic          credit_overflow_o, rx_overflow_o;

  serial_link_credit_ctrl #(.DataWidth(DW), .NumCredits(N), .ForceSendThresh(TH),
                            .TimeoutCycles(TO)) dut (
    .clk_i(clk), .rst_i(rst_i), .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i),
    .tx_ready_o(tx_ready_o), .link_out_o(link_out_o), .link_out_valid_o(link_out_valid_o),
    .link_out_ready_i(link_out_ready_i), .link_in_i(link_in_i),
    .link_in_valid_i(link_in_valid_i), .link_in_ready_o(link_in_ready_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .credits_avail_o(credits_avail_o), .credit_overflow_o(credit_overflow_o),
    .rx_overflow_o(rx_overflow_o));

  always #5 clk = ~clk;

  int errs = 0, checks = 0;
  bit chk_en = 0;
  int sent_data = 0, sent_cred = 0;

  task automatic chk(string name, logic [LW-1:0] got, logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: peer credits, pending returns, RX contents as a queue.
  int            m_cred, m_pend, m_idle;
  bit            m_ov, m_covf, m_rovf;
  logic [LW-1:0] m_out;
  logic [DW-1:0] m_q[$];

  function automatic bit m_txr();
    return !rst_i && (!m_ov || link_out_ready_i) && tx_valid_i && (m_cred > 0);
  endfunction

  always @(posedge clk) begin : model
    bit pop, ld, tmo, can_ld, take;
    int c, pold;
    if (rst_i) begin
      m_cred = N; m_pend = 0; m_idle = 0; m_ov = 0; m_out = '0;
      m_covf = 0; m_rovf = 0; m_q.delete();
    end else begin
      pop    = (m_q.size() > 0) && rx_ready_i;
      take   = m_txr();
      can_ld = !m_ov || link_out_ready_i;
      pold   = m_pend;
      tmo    = 0;
`ifdef SERIAL_LINK_CREDIT_TIMEOUT_EN
      tmo = (m_pend > 0) && (m_idle >= TO - 1);
`endif
      ld = 0;
      if (can_ld) begin
        if (take) begin
          m_out = {1'b1, CW'(m_pend), tx_data_i};
          m_cred = m_cred - 1; ld = 1;
        end else if (m_pend >= TH || tmo) begin
          m_out = {1'b0, CW'(m_pend), {DW{1'b0}}}; ld = 1;
        end
        m_ov = ld;
      end
      m_pend = ld ? int'(pop) : m_pend + int'(pop);
`ifdef SERIAL_LINK_CREDIT_TIMEOUT_EN
      if (ld || pold == 0) m_idle = 0;
      else if (m_idle < TO - 1) m_idle = m_idle + 1;
`endif
      if (pop) void'(m_q.pop_front());
      if (link_in_valid_i) begin
        c = m_cred + int'(link_in_i[DW +: CW]);
        if (c > N) begin c = N; m_covf = 1; end
        m_cred = c;
        if (link_in_i[LW-1]) begin
          if (m_q.size() < N) m_q.push_back(link_in_i[DW-1:0]);
          else m_rovf = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("link_out_valid", link_out_valid_o, m_ov);
      if (m_ov) chk("link_out", link_out_o, m_out);
      chk("tx_ready", tx_ready_o, m_txr());
      chk("link_in_ready", link_in_ready_o, !rst_i);
      chk("credits_avail", credits_avail_o, m_cred);
      chk("rx_valid", rx_valid_o, m_q.size() > 0);
      if (m_q.size() > 0) chk("rx_data", rx_data_o, m_q[0]);
      chk("credit_overflow", credit_overflow_o, m_covf);
      chk("rx_overflow", rx_overflow_o, m_rovf);
      if (link_out_valid_o && link_out_ready_i) begin
        if (link_out_o[LW-1]) sent_data++;
        else sent_cred++;
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic beat_in(bit d, int cr, logic [DW-1:0] data);
    link_in_valid_i = 1'b1;
    link_in_i = {d, CW'(cr), data};
  endtask

  logic [LW-1:0] exp;
  int first;

  initial begin
    rst_i = 1; tx_valid_i = 0; tx_data_i = '0; link_out_ready_i = 0;
    link_in_valid_i = 0; link_in_i = '0; rx_ready_i = 0;
    tick(); chk_en = 1;
    tx_valid_i = 1; link_out_ready_i = 1;
    tick();
    chk("rst_link_out_valid", link_out_valid_o, 0);
    chk("rst_credits", credits_avail_o, N);
    chk("rst_rx_valid", rx_valid_o, 0);
    chk("rst_tx_ready", tx_ready_o, 0);
    chk("rst_link_in_ready", link_in_ready_o, 0);
    rst_i = 0;

    // Spend all eight initial credits.
    for (int i = 0; i < 10; i++) begin tx_data_i = 64'h1000 + i; tick(); end
    chk("t1_tx_blocked", tx_ready_o, 0);
    chk("t1_credits_zero", credits_avail_o, 0);
    tx_valid_i = 0; tick(2);
    chk("t1_sent", sent_data, 8);

    // Peer returns 3 credits.
    tx_valid_i = 1; tx_data_i = 64'h2000;
    beat_in(0, 3, '0); tick(); link_in_valid_i = 0;
    chk("t2_credits", credits_avail_o, 3);
    for (int i = 1; i < 7; i++) begin tx_data_i = 64'h2000 + i; tick(); end
    tx_valid_i = 0; tick(2);
    chk("t2_sent", sent_data, 11);
    chk("t2_credits_zero", credits_avail_o, 0);

    // Six pops trigger a standalone credit return.
    rx_ready_i = 1;
    for (int i = 0; i < 6; i++) begin beat_in(1, 0, 64'd100 + i); tick(); end
    link_in_valid_i = 0; tick(2);
    exp = {1'b0, CW'(6), {DW{1'b0}}};
    chk("t3_cred_valid", link_out_valid_o, 1);
    chk("t3_cred_beat", link_out_o, exp);
    tick(2);
    chk("t3_cred_count", sent_cred, 1);

    // Two pops piggyback on the next payload beat.
    beat_in(1, 4, 64'd300); tick();
    beat_in(1, 0, 64'd301); tick();
    link_in_valid_i = 0; tick(2);
    tx_valid_i = 1; tx_data_i = 64'hA5; tick(); tx_valid_i = 0;
    exp = {1'b1, CW'(2), 64'hA5};
    chk("t4_piggyback", link_out_o, exp);
    tick(2);

    // Overfill the RX FIFO, then overshoot the credit count.
    rx_ready_i = 0;
    for (int i = 0; i < 9; i++) begin
      beat_in(1, (i == 0) ? 3 : 0, 64'd400 + i); tick();
      if (i == 7) chk("t5_no_ovf_at_full", rx_overflow_o, 0);
    end
    link_in_valid_i = 0;
    chk("t5_credits6", credits_avail_o, 6);
    chk("t5_rx_ovf", rx_overflow_o, 1);
    beat_in(0, 5, '0); tick(); link_in_valid_i = 0;
    chk("t5_credits_sat", credits_avail_o, N);
    chk("t5_credit_ovf", credit_overflow_o, 1);
    tick(5);
    chk("t5_rx_ovf_sticky", rx_overflow_o, 1);
    rx_ready_i = 1; beat_in(1, 0, 64'd500); tick(); link_in_valid_i = 0;
    tick(3); rx_ready_i = 0;

    // Mid-operation reset discards everything.
    rst_i = 1; tick(); rst_i = 0;
    chk("t6_rst_rx_valid", rx_valid_o, 0);
    chk("t6_rst_rx_ovf", rx_overflow_o, 0);
    chk("t6_rst_credit_ovf", credit_overflow_o, 0);
    chk("t6_rst_credits", credits_avail_o, N);

    // One pop then idle: forced return only with the timeout feature.
    rx_ready_i = 1; beat_in(1, 0, 64'd600); tick(); link_in_valid_i = 0;
    first = 0;
    for (int k = 2; k <= 1001; k++) begin
      tick();
      if (link_out_valid_o && first == 0) first = k;
    end
`ifdef SERIAL_LINK_CREDIT_TIMEOUT_EN
    chk("t7_timeout_cycle", first, 34);
`else
    chk("t7_no_timeout", first, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
